// File: rtl/eth_transmitter_if.sv
// eth_transmitter_if: host request/status, frame buffer SRAM port and
// serial link signals of the Ethernet-style serial transmitter.
// master: the transmitter side; slave: the host/SRAM/link side.
interface eth_transmitter_if;
    logic        start;
    logic [10:0] len;
    logic [7:0]  d;
    logic [10:0] a;
    logic        n_cs;
    logic        n_oe;
    logic        sck;
    logic        sda;
    logic        busy;
    logic        done;

    modport master (
        input  start, len, d,
        output a, n_cs, n_oe, sck, sda, busy, done
    );

    modport slave (
        output start, len, d,
        input  a, n_cs, n_oe, sck, sda, busy, done
    );
endinterface

// File: rtl/eth_transmitter.sv
// eth_transmitter: fetches len bytes from a frame buffer SRAM and sends them
// LSB-first on a two-phase serial link (sck low half, sck high half per bit).
// Build option: define ETH_TX_FCS_EN to append an Ethernet CRC-32 FCS
// (reflected 0xEDB88320, init all-ones, sent inverted, LSB-first).
module eth_transmitter (
    input logic              clk,
    input logic              n_rst,
    eth_transmitter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
`ifdef ETH_TX_FCS_EN
        FCS,
`endif
        DONE
    } state_t;

    state_t      state_q, state_n;
    logic [10:0] len_q,   len_n;
    logic [10:0] a_q,     a_n;
    logic [7:0]  shreg_q, shreg_n;
    logic [4:0]  bit_q,   bit_n;
    logic        sck_q,   sck_n;
    logic        sda_q,   sda_n;
    logic        more_bytes;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_n;
    logic [31:0] crc_upd;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        crc_step = {1'b0, c[31:1]} ^ (((c[0] ^ b) == 1'b1) ? 32'hEDB88320 : 32'h0000_0000);
    endfunction
`endif

    // Bytes sent so far is a+1; another byte follows while that is below len.
    assign more_bytes = ({1'b0, a_q} + 12'd1) < {1'b0, len_q};

`ifdef ETH_TX_FCS_EN
    // CRC including the payload bit currently on the wire (shreg[0]).
    assign crc_upd = crc_step(crc_q, shreg_q[0]);
`endif

    // State and datapath registers; reset clears everything so no partial frame resumes.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            a_q     <= '0;
            shreg_q <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            sda_q   <= 1'b0;
`ifdef ETH_TX_FCS_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            len_q   <= len_n;
            a_q     <= a_n;
            shreg_q <= shreg_n;
            bit_q   <= bit_n;
            sck_q   <= sck_n;
            sda_q   <= sda_n;
`ifdef ETH_TX_FCS_EN
            crc_q   <= crc_n;
`endif
        end
    end

    // Next-state and next-datapath logic; sck/sda are produced as registered values.
    always_comb begin
        state_n = state_q;
        len_n   = len_q;
        a_n     = a_q;
        shreg_n = shreg_q;
        bit_n   = bit_q;
        sck_n   = sck_q;
        sda_n   = sda_q;
`ifdef ETH_TX_FCS_EN
        crc_n   = crc_q;
`endif

        unique case (state_q)
            IDLE: begin
                sck_n = 1'b0;
                sda_n = 1'b0;
                a_n   = '0;
                if (bus.start && (bus.len != 11'd0)) begin
                    len_n   = bus.len;
                    state_n = FETCH;
`ifdef ETH_TX_FCS_EN
                    crc_n   = '1;
`endif
                end
            end

            FETCH: begin
                // SRAM data is valid now; first bit goes out with the load.
                sck_n   = 1'b0;
                shreg_n = bus.d;
                sda_n   = bus.d[0];
                bit_n   = '0;
                state_n = SHIFT;
            end

            SHIFT: begin
                if (!sck_q) begin
                    // Phase L -> H: raise sck, sda held at the current bit.
                    sck_n = 1'b1;
                    sda_n = shreg_q[0];
                end else begin
                    sck_n = 1'b0;
`ifdef ETH_TX_FCS_EN
                    crc_n = crc_upd;
`endif
                    if (bit_q == 5'd7) begin
                        if (more_bytes) begin
                            a_n     = a_q + 11'd1;
                            state_n = FETCH;
                        end else begin
                            a_n   = '0;
`ifdef ETH_TX_FCS_EN
                            // Last payload bit is folded in above; FCS bit 0 follows directly.
                            bit_n   = '0;
                            sda_n   = ~crc_upd[0];
                            state_n = FCS;
`else
                            sda_n   = 1'b0;
                            state_n = DONE;
`endif
                        end
                    end else begin
                        shreg_n = {1'b0, shreg_q[7:1]};
                        sda_n   = shreg_q[1];
                        bit_n   = bit_q + 5'd1;
                    end
                end
            end

`ifdef ETH_TX_FCS_EN
            FCS: begin
                if (!sck_q) begin
                    sck_n = 1'b1;
                    sda_n = ~crc_q[0];
                end else begin
                    sck_n = 1'b0;
                    if (bit_q == 5'd31) begin
                        sda_n   = 1'b0;
                        state_n = DONE;
                    end else begin
                        // The CRC register doubles as the FCS shift register.
                        crc_n = {1'b0, crc_q[31:1]};
                        sda_n = ~crc_q[1];
                        bit_n = bit_q + 5'd1;
                    end
                end
            end
`endif

            DONE: begin
                sck_n   = 1'b0;
                sda_n   = 1'b0;
                a_n     = '0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.a    = a_q;
    assign bus.sck  = sck_q;
    assign bus.sda  = sda_q;
    assign bus.busy = (state_q != IDLE) && (state_q != DONE);
    assign bus.done = (state_q == DONE);
    assign bus.n_cs = !((state_q == FETCH) || (state_q == SHIFT));
    assign bus.n_oe = !((state_q == FETCH) || (state_q == SHIFT));

endmodule
